// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder is reused LSB-first over WIDTH cycles
// to form {cout,sum} = a + b + cin, with an IDLE/RUN/DONE handshake around it.

module fulladder_structural (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic f_s,
  output logic f_c
);
  logic p, g, t;

  xor u_x1 (p, x, y);
  xor u_x2 (f_s, p, z);
  and u_a1 (g, x, y);
  and u_a2 (t, p, z);
  or  u_o1 (f_c, g, t);
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;
  logic             fa_s, fa_c;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  fulladder_structural u_fa (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .z   (carry_q),
    .f_s (fa_s),
    .f_c (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last_bit ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_c;
          // Hold the counter on the final bit so it never wraps for power-of-two widths.
          if (!last_bit) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            sum_q  <= {fa_s, res_q[WIDTH-1:1]};
            cout_q <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised self-checking bench for serial_adder_ctrl at WIDTH=8.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  int errors = 0;
  int checks = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Drive one add (start for a single cycle) and wait for done, sampling on negedges.
  // lat counts negedges from acceptance to the done sample (-1 on timeout).
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bc;
    run_add(8'h00, 8'h00, 1'b0, lat, bc);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL zero_latency: got %0d, expected 9", lat);
    end
    checks++;
    if (bc !== 9) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d, expected 9", bc);
    end
    checks++;
    if ({cout, sum} !== 9'h000) begin
      errors++;
      $display("FAIL zero_result: got %h, expected 000", {cout, sum});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL zero_after_done: busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_carry;
    int lat, bc;
    run_add(8'hFF, 8'h01, 1'b0, lat, bc);
    checks++;
    if (lat !== 9 || {cout, sum} !== 9'h100) begin
      errors++;
      $display("FAIL carry_ff_01: lat=%0d res=%h, expected lat 9 res 100", lat, {cout, sum});
    end
    run_add(8'hFF, 8'hFF, 1'b1, lat, bc);
    checks++;
    if (lat !== 9 || {cout, sum} !== 9'h1FF) begin
      errors++;
      $display("FAIL carry_ff_ff_1: lat=%0d res=%h, expected lat 9 res 1FF", lat, {cout, sum});
    end
  endtask

  task automatic test_hold;
    int lat, bc;
    int bad;
    run_add(8'hA5, 8'h5A, 1'b0, lat, bc);
    checks++;
    if ({cout, sum} !== 9'h0FF) begin
      errors++;
      $display("FAIL hold_first: got %h, expected 0FF", {cout, sum});
    end
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if ({cout, sum} !== 9'h0FF) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_during_run: %0d samples differed from 0FF, expected 0", bad);
    end
    checks++;
    if (lat !== 9 || {cout, sum} !== 9'h080) begin
      errors++;
      $display("FAIL hold_second: lat=%0d res=%h, expected lat 9 res 080", lat, {cout, sum});
    end
  endtask

  task automatic test_start_ignored;
    int dones;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'hEE; b = 8'hCC; cin = 1'b1;
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 3) begin
        a = 8'h01; b = 8'h01; start = 1'b1;
      end
      if (n == 5) start = 1'b0;
      if (done) dones++;
      if (n < 10) @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d pulses, expected 1", dones);
    end
    checks++;
    if ({cout, sum} !== 9'h030) begin
      errors++;
      $display("FAIL ignore_result: got %h, expected 030", {cout, sum});
    end
    for (int n = 0; n < 4; n++) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_no_requeue: busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_reset_midrun;
    int lat, bc, dones;
    @(negedge clk);
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 4; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy=%b done=%b sum=%h cout=%b, expected all 0", busy, done, sum, cout);
    end
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d pulses, expected 0", dones);
    end
    run_add(8'h12, 8'h34, 1'b1, lat, bc);
    checks++;
    if (lat !== 9 || {cout, sum} !== 9'h047) begin
      errors++;
      $display("FAIL midrun_after_release: lat=%0d res=%h, expected lat 9 res 047", lat, {cout, sum});
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    int cyc, prev, k, rerr, serr;
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    start = 1'b1;
    cyc = 0; prev = -1; k = 0; rerr = 0; serr = 0;
    while (cyc < 12000 && k < 1000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checks++;
        if ({cout, sum} !== exp) begin
          errors++;
          if (rerr < 5) $display("FAIL b2b_result #%0d: got %h, expected %h", k, {cout, sum}, exp);
          rerr++;
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev !== 10) begin
            errors++;
            if (serr < 5) $display("FAIL b2b_spacing #%0d: got %0d, expected 10", k, cyc - prev);
            serr++;
          end
        end
        prev = cyc;
        k++;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 1000) begin
      errors++;
      $display("FAIL b2b_count: completed %0d adds, expected 1000", k);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_hold();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
